// File: rtl/uart_pkg.sv
`default_nettype none
// ==== uart_pkg : shared UART constants, FSM state type and baud divisor helper ====
// Rev 1.0
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Oversample-tick divisor; truncating division, shared with the transmitter.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ==== uart_rx_if : serial line input and received-byte outputs of uart_rx ====
// Rev 1.0
interface uart_rx_if
  import uart_pkg::*;
;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 framing_err;
  logic                 busy;

  modport master (output rx, input data, input valid, input framing_err, input busy);
  modport slave  (input rx, output data, output valid, output framing_err, output busy);
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ==== uart_baud_gen : prescaler emitting one tick every DIV clocks, with sync clear ====
// Rev 1.0
module uart_baud_gen #(
  parameter int DIV = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  output logic      tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ==== uart_rx : 8N1 receiver, 16x oversampling, start/stop validation ====
// Rev 1.0 -- UART_RX_MAJORITY_EN selects 2-of-3 mid-bit voting instead of a single sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input wire logic   clk,
  input wire logic   rst,
  uart_rx_if.slave   bus
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

  state_t               state;
  logic                 sync1;
  logic                 rxs;
  logic [3:0]           sample_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 s8;
  logic                 tick;
  logic                 prescale_clear;
  logic                 decide;
  logic                 bit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rxs   <= sync1;
    end
  end

  assign prescale_clear = (state == IDLE) || (state == WAIT_IDLE);

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (prescale_clear),
    .tick  (tick)
  );

  // The decision tick is the one on which sample_cnt advances 8 -> 9.
  assign decide = tick && (sample_cnt == 4'd8);

`ifdef UART_RX_MAJORITY_EN
  logic s7;

  always_ff @(posedge clk) begin
    if (rst) begin
      s7 <= 1'b1;
    end else if (tick && (sample_cnt == 4'd6)) begin
      s7 <= rxs;
    end
  end

  // Third vote is rxs itself, taken on the decision tick.
  assign bit_val = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
`else
  assign bit_val = s8;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sample_cnt      <= 4'd0;
      bit_idx         <= 3'd0;
      shreg           <= '0;
      s8              <= 1'b1;
      bus.data        <= '0;
      bus.valid       <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.valid       <= 1'b0;
      bus.framing_err <= 1'b0;

      if (tick) begin
        sample_cnt <= sample_cnt + 4'd1;
        if (sample_cnt == 4'd7) begin
          s8 <= rxs;
        end
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            sample_cnt <= 4'd0;
            state      <= START;
            bus.busy   <= 1'b1;
          end
        end

        START: begin
          if (decide) begin
            if (bit_val) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              bit_idx <= 3'd0;
              state   <= DATA;
            end
          end
        end

        DATA: begin
          if (decide) begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (decide) begin
            if (bit_val) begin
              bus.data  <= shreg;
              bus.valid <= 1'b1;
              state     <= IDLE;
              bus.busy  <= 1'b0;
            end else begin
              bus.framing_err <= 1'b1;
              state           <= WAIT_IDLE;
            end
          end
        end

        // Hold here through a break so a long low line cannot retrigger.
        WAIT_IDLE: begin
          if (rxs) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
